sockit_spi_ser: RTL

- Command executor on the far end of the register block's command interface.
- Consumes command-output transactions (control + data), runs one single-bit SPI master transfer of 1..32 bits, drives SCLK/MOSI/SS_N, samples MISO.
- Returns received data on the command-input interface.
- Sits between the CPU register block and the SPI pads, single clock domain.

---
 rtl/sockit_spi_ser.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/sockit_spi_ser.sv
// sockit_spi_ser: single-bit SPI master that runs one 1..32 bit transfer per command.
// Optional macro SOCKIT_SPI_LOOPBACK_EN: spi_cfg[23]=1 feeds MOSI back into the sample path.
module sockit_spi_ser #(
    parameter int CCO = 12,
    parameter int CCI = 4,
    parameter int CDW = 32,
    parameter int SSN = 8,
    parameter int DIV = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [31:0]    spi_cfg,
    input  logic           cmo_vld,
    input  logic [CCO-1:0] cmo_ctl,
    input  logic [CDW-1:0] cmo_dat,
    output logic           cmo_rdy,
    output logic           cmi_vld,
    output logic [CCI-1:0] cmi_ctl,
    output logic [CDW-1:0] cmi_dat,
    input  logic           cmi_rdy,
    output logic           spi_sclk,
    output logic [SSN-1:0] spi_ss_n,
    output logic           spi_mosi,
    input  logic           spi_miso
);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, RESP} state_t;

    localparam int DCW = $clog2(DIV + 1);
    localparam logic [DCW-1:0] DIV_RELOAD = DCW'(DIV - 1);
    // One extra cycle on accept gives SS a cycle of setup before the first SETUP tick.
    localparam logic [DCW-1:0] DIV_FIRST = DCW'(DIV);

    state_t         state_q;
    logic [DCW-1:0] div_q;
    logic [5:0]     bit_q;
    logic [4:0]     len_q;
    logic           die_q, doe_q, hld_q, dir_q, pol_q, pha_q;
    logic [CDW-1:0] tx_q, rx_q;
    logic           sclk_q, mosi_q;
    logic [SSN-1:0] ss_n_q;
    logic           cmo_rdy_q, cmi_vld_q;
    logic [CCI-1:0] cmi_ctl_q;
    logic [CDW-1:0] cmi_dat_q;

    logic tick, lead, last_smp, smp_bit;

    function automatic logic head_bit(input logic [CDW-1:0] d, input logic [4:0] l, input logic dir);
        return dir ? d[l] : d[0];
    endfunction

    function automatic logic [CDW-1:0] shift_tx(input logic [CDW-1:0] d, input logic dir);
        return dir ? (d << 1) : (d >> 1);
    endfunction

    assign tick     = (div_q == '0);
    assign lead     = (sclk_q == pol_q);
    // Trailing edge that completes sample number len+1 ends the shift phase.
    assign last_smp = ((bit_q + {5'd0, pha_q}) == ({1'b0, len_q} + 6'd1));

`ifdef SOCKIT_SPI_LOOPBACK_EN
    logic lb_q;
    logic unused_cfg;
    assign smp_bit    = lb_q ? mosi_q : spi_miso;
    assign unused_cfg = ^{spi_cfg[22:7], spi_cfg[5:2], cmo_ctl[3:0]};
`else
    logic unused_cfg;
    assign smp_bit    = spi_miso;
    assign unused_cfg = ^{spi_cfg[23:7], spi_cfg[5:2], cmo_ctl[3:0]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            len_q     <= '0;
            die_q     <= 1'b0;
            doe_q     <= 1'b0;
            hld_q     <= 1'b0;
            dir_q     <= 1'b0;
            pol_q     <= 1'b0;
            pha_q     <= 1'b0;
            tx_q      <= '0;
            rx_q      <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b1;
            ss_n_q    <= '1;
            cmo_rdy_q <= 1'b1;
            cmi_vld_q <= 1'b0;
            cmi_ctl_q <= '0;
            cmi_dat_q <= '0;
`ifdef SOCKIT_SPI_LOOPBACK_EN
            lb_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    sclk_q <= spi_cfg[1];
                    mosi_q <= 1'b1;
                    if (cmo_vld) begin
                        state_q   <= SETUP;
                        cmo_rdy_q <= 1'b0;
                        div_q     <= DIV_FIRST;
                        bit_q     <= '0;
                        rx_q      <= '0;
                        len_q     <= cmo_ctl[11:7];
                        die_q     <= cmo_ctl[6];
                        doe_q     <= cmo_ctl[5];
                        hld_q     <= cmo_ctl[4];
                        dir_q     <= spi_cfg[6];
                        pol_q     <= spi_cfg[1];
                        pha_q     <= spi_cfg[0];
                        ss_n_q    <= ~spi_cfg[24 +: SSN];
`ifdef SOCKIT_SPI_LOOPBACK_EN
                        lb_q      <= spi_cfg[23];
`endif
                        if (spi_cfg[0]) begin
                            tx_q <= cmo_dat;
                        end else begin
                            tx_q   <= shift_tx(cmo_dat, spi_cfg[6]);
                            mosi_q <= cmo_ctl[5] ? head_bit(cmo_dat, cmo_ctl[11:7], spi_cfg[6]) : 1'b1;
                        end
                    end
                end
                SETUP: begin
                    if (tick) begin
                        state_q <= SHIFT;
                        div_q   <= DIV_RELOAD;
                    end else begin
                        div_q <= div_q - 1'b1;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        div_q  <= DIV_RELOAD;
                        sclk_q <= ~sclk_q;
                        if (lead == pha_q) begin
                            // Drive edge: leading for pha=1, trailing for pha=0.
                            if (!lead && last_smp) begin
                                state_q <= DONE;
                                mosi_q  <= 1'b1;
                            end else begin
                                mosi_q <= doe_q ? head_bit(tx_q, len_q, dir_q) : 1'b1;
                                tx_q   <= shift_tx(tx_q, dir_q);
                            end
                        end else begin
                            if (dir_q) rx_q <= {rx_q[CDW-2:0], smp_bit};
                            else       rx_q[bit_q[4:0]] <= smp_bit;
                            bit_q <= bit_q + 6'd1;
                            if (!lead && last_smp) begin
                                state_q <= DONE;
                                mosi_q  <= 1'b1;
                            end
                        end
                    end else begin
                        div_q <= div_q - 1'b1;
                    end
                end
                DONE: begin
                    if (tick) begin
                        div_q <= '0;
                        if (!hld_q) ss_n_q <= '1;
                        if (die_q) begin
                            state_q   <= RESP;
                            cmi_vld_q <= 1'b1;
                            cmi_dat_q <= rx_q;
                            cmi_ctl_q <= {hld_q & ~(&ss_n_q), {(CCI-1){1'b0}}};
                        end else begin
                            state_q   <= IDLE;
                            cmo_rdy_q <= 1'b1;
                        end
                    end else begin
                        div_q <= div_q - 1'b1;
                    end
                end
                RESP: begin
                    if (cmi_rdy) begin
                        state_q   <= IDLE;
                        cmi_vld_q <= 1'b0;
                        cmo_rdy_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmo_rdy  = cmo_rdy_q;
    assign cmi_vld  = cmi_vld_q;
    assign cmi_ctl  = cmi_ctl_q;
    assign cmi_dat  = cmi_dat_q;
    assign spi_sclk = sclk_q;
    assign spi_ss_n = ss_n_q;
    assign spi_mosi = mosi_q;
endmodule
